// File: rtl/banco_registradores_v2.sv
// Parametrised register file: power-up init sequencer, three write-bypassed registered
// read ports (D1, D2, SWR) and an optional hardwired-zero register 0.
module banco_registradores_v2 #(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 32,
    parameter int                ZERO_REG  = 0,
    parameter int                LINK_REG  = 30,
    parameter int                SP_IDX    = 28,
    parameter logic [DATA_W-1:0] SP_INIT   = DATA_W'(48),
    parameter int                GP_IDX    = 29,
    parameter logic [DATA_W-1:0] GP_INIT   = DATA_W'(49),
    parameter int                TRUE_IDX  = 31,
    parameter logic [DATA_W-1:0] TRUE_INIT = DATA_W'(1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] read1,
    input  logic [ADDR_W-1:0] read2,
    input  logic              ctrl_d2,
    input  logic              ctrl_jal,
    input  logic              read_en,
    output logic [DATA_W-1:0] D1,
    output logic [DATA_W-1:0] D2,
    output logic [DATA_W-1:0] SWR,
    output logic              ready
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(SP_IDX);
    localparam logic [ADDR_W-1:0] GP_ADDR   = ADDR_W'(GP_IDX);
    localparam logic [ADDR_W-1:0] TRUE_ADDR = ADDR_W'(TRUE_IDX);
    localparam bit                HAS_ZERO  = (ZERO_REG != 0);

    // state | meaning
    // INIT  | sequencer loads reg[cnt] with its reset value; commands ignored, outputs 0
    // RUN   | ready=1; writes and reads accepted
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] regs [DEPTH];

    logic [ADDR_W-1:0] init_addr;
    logic [ADDR_W-1:0] d1_addr;
    logic [ADDR_W-1:0] d2_addr;
    logic              wr_blocked;
    logic              wr_accept;
    logic [DATA_W-1:0] d1_next;
    logic [DATA_W-1:0] d2_next;
    logic [DATA_W-1:0] swr_next;

    function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] idx);
        if (idx == SP_ADDR)   return SP_INIT;
        if (idx == GP_ADDR)   return GP_INIT;
        if (idx == TRUE_ADDR) return TRUE_INIT;
        return '0;
    endfunction

    // Hardwired zero wins over bypass; otherwise a same-edge write overrides storage.
    function automatic logic [DATA_W-1:0] read_value(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              accept,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (HAS_ZERO && (addr == '0)) return '0;
        if (accept && (addr == waddr)) return wdata;
        return stored;
    endfunction

    assign init_addr = cnt[ADDR_W-1:0];

    always_comb begin
        d1_addr    = ctrl_jal ? LINK_ADDR : read1;
        d2_addr    = ctrl_d2 ? read2 : write_reg;
        wr_blocked = HAS_ZERO && (write_reg == '0);
        wr_accept  = (state == ST_RUN) && write_en && !wr_blocked;
        d1_next    = read_value(d1_addr, regs[d1_addr], wr_accept, write_reg, data);
        d2_next    = read_value(d2_addr, regs[d2_addr], wr_accept, write_reg, data);
        swr_next   = read_value(write_reg, regs[write_reg], wr_accept, write_reg, data);
    end

    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            regs[init_addr] <= init_value(init_addr);
        end else if (wr_accept) begin
            regs[write_reg] <= data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
            cnt   <= '0;
            ready <= 1'b0;
            D1    <= '0;
            D2    <= '0;
            SWR   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (read_en) begin
                        D1  <= d1_next;
                        D2  <= d2_next;
                        SWR <= swr_next;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_banco_registradores_v2.sv
// Bench for banco_registradores_v2: default bank, ZERO_REG=1 bank and a 16x8 bank,
// checked against an array-based model of the register-file behaviour.
module tb_banco_registradores_v2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        write_en, ctrl_d2, ctrl_jal, read_en;
    logic [4:0]  write_reg, read1, read2;
    logic [31:0] data;
    logic [31:0] d1_a, d2_a, swr_a, d1_z, d2_z, swr_z;
    logic        ready_a, ready_z;

    logic        write_en_s, ctrl_d2_s, ctrl_jal_s, read_en_s;
    logic [2:0]  write_reg_s, read1_s, read2_s;
    logic [15:0] data_s, d1_s, d2_s, swr_s;
    logic        ready_s;

    always #5 clock = ~clock;

    banco_registradores_v2 dut_a (
        .clock(clock), .reset_n(reset_n), .write_en(write_en), .write_reg(write_reg),
        .data(data), .read1(read1), .read2(read2), .ctrl_d2(ctrl_d2), .ctrl_jal(ctrl_jal),
        .read_en(read_en), .D1(d1_a), .D2(d2_a), .SWR(swr_a), .ready(ready_a)
    );

    banco_registradores_v2 #(.ZERO_REG(1)) dut_z (
        .clock(clock), .reset_n(reset_n), .write_en(write_en), .write_reg(write_reg),
        .data(data), .read1(read1), .read2(read2), .ctrl_d2(ctrl_d2), .ctrl_jal(ctrl_jal),
        .read_en(read_en), .D1(d1_z), .D2(d2_z), .SWR(swr_z), .ready(ready_z)
    );

    banco_registradores_v2 #(
        .DATA_W(16), .ADDR_W(3), .LINK_REG(6),
        .SP_IDX(4), .SP_INIT(16'd48), .GP_IDX(5), .GP_INIT(16'd49),
        .TRUE_IDX(7), .TRUE_INIT(16'd1)
    ) dut_s (
        .clock(clock), .reset_n(reset_n), .write_en(write_en_s), .write_reg(write_reg_s),
        .data(data_s), .read1(read1_s), .read2(read2_s), .ctrl_d2(ctrl_d2_s),
        .ctrl_jal(ctrl_jal_s), .read_en(read_en_s), .D1(d1_s), .D2(d2_s), .SWR(swr_s),
        .ready(ready_s)
    );

    logic [31:0] act_d1 [2];
    logic [31:0] act_d2 [2];
    logic [31:0] act_swr [2];
    logic        act_ready [2];
    assign act_d1[0] = d1_a;   assign act_d1[1] = d1_z;
    assign act_d2[0] = d2_a;   assign act_d2[1] = d2_z;
    assign act_swr[0] = swr_a; assign act_swr[1] = swr_z;
    assign act_ready[0] = ready_a;
    assign act_ready[1] = ready_z;

    int tests = 0;
    int fails = 0;

    // Model: index 0 = plain bank, index 1 = bank with hardwired register 0.
    logic [31:0] mem [2][32];
    logic [31:0] exp_d1 [2];
    logic [31:0] exp_d2 [2];
    logic [31:0] exp_swr [2];
    logic        exp_ready;
    int          init_edges;

    function automatic logic [31:0] init_val(int i);
        case (i)
            28:      return 32'd48;
            29:      return 32'd49;
            31:      return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(int j, logic [4:0] a);
        if (j == 1 && a == 5'd0) return 32'd0;
        if (write_en && a == write_reg) return data;
        return mem[j][a];
    endfunction

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic model_reset();
        exp_ready  = 1'b0;
        init_edges = 0;
        for (int j = 0; j < 2; j++) begin
            exp_d1[j]  = '0;
            exp_d2[j]  = '0;
            exp_swr[j] = '0;
        end
    endtask

    task automatic set_cmd(input logic we, input logic [4:0] wr, input logic [31:0] d,
                           input logic [4:0] r1, input logic [4:0] r2,
                           input logic cd2, input logic jal, input logic re);
        write_en = we; write_reg = wr; data = d; read1 = r1; read2 = r2;
        ctrl_d2 = cd2; ctrl_jal = jal; read_en = re;
    endtask

    task automatic set_random_cmd();
        set_cmd(1'($urandom_range(0, 1)), rnd_addr(), 32'($urandom), rnd_addr(), rnd_addr(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Advances one rising edge, updates the model with the command seen there, then
    // leaves time 1 unit after the edge for sampling.
    task automatic drive_edge();
        logic [4:0] a1, a2;
        @(posedge clock);
        if (!exp_ready) begin
            init_edges++;
            if (init_edges == 32) begin
                exp_ready = 1'b1;
                for (int j = 0; j < 2; j++)
                    for (int i = 0; i < 32; i++) mem[j][i] = init_val(i);
            end
        end else begin
            a1 = ctrl_jal ? 5'd30 : read1;
            a2 = ctrl_d2 ? read2 : write_reg;
            for (int j = 0; j < 2; j++) begin
                if (read_en) begin
                    exp_d1[j]  = model_read(j, a1);
                    exp_d2[j]  = model_read(j, a2);
                    exp_swr[j] = model_read(j, write_reg);
                end
                if (write_en && !(j == 1 && write_reg == 5'd0)) mem[j][write_reg] = data;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        set_cmd(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        write_en_s = 1'b0; write_reg_s = 3'd0; data_s = 16'd0; read1_s = 3'd0;
        read2_s = 3'd0; ctrl_d2_s = 1'b0; ctrl_jal_s = 1'b0; read_en_s = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        for (int j = 0; j < 2; j++) begin
            tests++;
            if ({act_ready[j], act_d1[j], act_d2[j], act_swr[j]} !== 97'd0) begin
                fails++;
                $display("FAIL reset_state dut%0d: ready=%b d1=%h d2=%h swr=%h, want all 0",
                         j, act_ready[j], act_d1[j], act_d2[j], act_swr[j]);
            end
        end
        tests++;
        if ({ready_s, d1_s, d2_s, swr_s} !== 49'd0) begin
            fails++;
            $display("FAIL reset_state small: ready=%b d1=%h d2=%h swr=%h, want all 0",
                     ready_s, d1_s, d2_s, swr_s);
        end
        @(posedge clock);
        #2 reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            set_random_cmd();
            drive_edge();
            for (int j = 0; j < 2; j++) begin
                tests++;
                if (act_ready[j] !== (k == 32) ||
                    {act_d1[j], act_d2[j], act_swr[j]} !== {exp_d1[j], exp_d2[j], exp_swr[j]}) begin
                    fails++;
                    $display("FAIL init_seq dut%0d edge %0d: ready=%b d1=%h d2=%h swr=%h, want ready=%b outputs 0",
                             j, k, act_ready[j], act_d1[j], act_d2[j], act_swr[j], k == 32);
                end
            end
            tests++;
            if (ready_s !== (k >= 8)) begin
                fails++;
                $display("FAIL init_small edge %0d: ready=%b, want %b", k, ready_s, k >= 8);
            end
        end
    endtask

    task automatic test_init_table();
        for (int i = 0; i < 32; i++) begin
            set_cmd(1'b0, rnd_addr(), 32'($urandom), 5'(i), 5'(31 - i), 1'b1, 1'b0, 1'b1);
            drive_edge();
            for (int j = 0; j < 2; j++) begin
                tests++;
                if ({act_d1[j], act_d2[j], act_swr[j]} !== {exp_d1[j], exp_d2[j], exp_swr[j]}) begin
                    fails++;
                    $display("FAIL init_table dut%0d reg %0d: got %h %h %h, want %h %h %h", j, i,
                             act_d1[j], act_d2[j], act_swr[j], exp_d1[j], exp_d2[j], exp_swr[j]);
                end
            end
        end
        set_cmd(1'b0, 5'd31, 32'd0, 5'd28, 5'd29, 1'b1, 1'b0, 1'b1);
        drive_edge();
        for (int j = 0; j < 2; j++) begin
            tests++;
            if ({act_d1[j], act_d2[j], act_swr[j]} !== {32'd48, 32'd49, 32'd1}) begin
                fails++;
                $display("FAIL init_sp_gp_true dut%0d: got %0d %0d %0d, want 48 49 1",
                         j, act_d1[j], act_d2[j], act_swr[j]);
            end
        end
    endtask

    task automatic test_bypass();
        set_cmd(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd9, 1'b1, 1'b0, 1'b1);
        drive_edge();
        set_cmd(1'b0, 5'd5, 32'd0, 5'd5, 5'd9, 1'b1, 1'b0, 1'b1);
        drive_edge();
        set_cmd(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
        drive_edge();
        for (int j = 0; j < 2; j++) begin
            tests++;
            if (act_d1[j] !== 32'hDEADBEEF || act_swr[j] !== 32'hDEADBEEF) begin
                fails++;
                $display("FAIL bypass_hold dut%0d: d1=%h swr=%h, want deadbeef", j, act_d1[j], act_swr[j]);
            end
        end
        set_cmd(1'b0, 5'd5, 32'd0, 5'd5, 5'd9, 1'b1, 1'b0, 1'b1);
        drive_edge();
        for (int j = 0; j < 2; j++) begin
            tests++;
            if (act_d1[j] !== 32'h12345678 || act_d2[j] !== exp_d2[j]) begin
                fails++;
                $display("FAIL write_no_read dut%0d: d1=%h d2=%h, want 12345678 %h",
                         j, act_d1[j], act_d2[j], exp_d2[j]);
            end
        end
    endtask

    task automatic test_select();
        set_cmd(1'b1, 5'd30, 32'h100, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        drive_edge();
        set_cmd(1'b1, 5'd3, 32'h33, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        drive_edge();
        set_cmd(1'b0, 5'd3, 32'd0, 5'd7, 5'd9, 1'b0, 1'b1, 1'b1);
        drive_edge();
        for (int j = 0; j < 2; j++) begin
            tests++;
            if ({act_d1[j], act_d2[j], act_swr[j]} !== {32'h100, 32'h33, 32'h33}) begin
                fails++;
                $display("FAIL select_jal_d2 dut%0d: got %h %h %h, want 100 33 33",
                         j, act_d1[j], act_d2[j], act_swr[j]);
            end
        end
    endtask

    task automatic test_zero_reg();
        set_cmd(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        drive_edge();
        tests++;
        if ({d1_a, d2_a, swr_a} !== {3{32'hFFFFFFFF}}) begin
            fails++;
            $display("FAIL reg0_plain_same_edge: got %h %h %h, want ffffffff x3", d1_a, d2_a, swr_a);
        end
        tests++;
        if ({d1_z, d2_z, swr_z} !== 96'd0) begin
            fails++;
            $display("FAIL reg0_zero_same_edge: got %h %h %h, want 0 x3", d1_z, d2_z, swr_z);
        end
        set_cmd(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        drive_edge();
        tests++;
        if ({d1_a, d2_a, swr_a} !== {3{32'hFFFFFFFF}}) begin
            fails++;
            $display("FAIL reg0_plain_later: got %h %h %h, want ffffffff x3", d1_a, d2_a, swr_a);
        end
        tests++;
        if ({d1_z, d2_z, swr_z} !== 96'd0) begin
            fails++;
            $display("FAIL reg0_zero_later: got %h %h %h, want 0 x3", d1_z, d2_z, swr_z);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_random_cmd();
            drive_edge();
            for (int j = 0; j < 2; j++) begin
                tests++;
                if ({act_d1[j], act_d2[j], act_swr[j]} !== {exp_d1[j], exp_d2[j], exp_swr[j]}) begin
                    fails++;
                    $display("FAIL random dut%0d cycle %0d: got %h %h %h, want %h %h %h", j, n,
                             act_d1[j], act_d2[j], act_swr[j], exp_d1[j], exp_d2[j], exp_swr[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        set_cmd(1'b1, 5'd5, 32'h55, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1);
        drive_edge();
        for (int j = 0; j < 2; j++) begin
            tests++;
            if (act_d1[j] !== 32'h55) begin
                fails++;
                $display("FAIL pre_reset_read dut%0d: d1=%h, want 55", j, act_d1[j]);
            end
        end
        set_cmd(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        for (int j = 0; j < 2; j++) begin
            tests++;
            if ({act_ready[j], act_d1[j], act_d2[j], act_swr[j]} !== 97'd0) begin
                fails++;
                $display("FAIL async_reset_run dut%0d: ready=%b d1=%h d2=%h swr=%h, want all 0",
                         j, act_ready[j], act_d1[j], act_d2[j], act_swr[j]);
            end
        end
        @(posedge clock);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_random_cmd();
            drive_edge();
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        for (int j = 0; j < 2; j++) begin
            tests++;
            if (act_ready[j] !== 1'b0) begin
                fails++;
                $display("FAIL async_reset_init dut%0d: ready=%b, want 0", j, act_ready[j]);
            end
        end
        @(posedge clock);
        #2 reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            set_random_cmd();
            drive_edge();
            for (int j = 0; j < 2; j++) begin
                tests++;
                if (act_ready[j] !== (k == 32) || act_d1[j] !== 32'd0) begin
                    fails++;
                    $display("FAIL reinit dut%0d edge %0d: ready=%b d1=%h, want ready=%b d1=0",
                             j, k, act_ready[j], act_d1[j], k == 32);
                end
            end
        end
        set_cmd(1'b0, 5'd28, 32'd0, 5'd5, 5'd28, 1'b1, 1'b0, 1'b1);
        drive_edge();
        for (int j = 0; j < 2; j++) begin
            tests++;
            if ({act_d1[j], act_d2[j], act_swr[j]} !== {32'd0, 32'd48, 32'd48}) begin
                fails++;
                $display("FAIL reload_values dut%0d: got %0d %0d %0d, want 0 48 48",
                         j, act_d1[j], act_d2[j], act_swr[j]);
            end
        end
    endtask

    task automatic test_sweep();
        write_en_s = 1'b0; write_reg_s = 3'd7; read1_s = 3'd4; read2_s = 3'd5;
        ctrl_d2_s = 1'b1; ctrl_jal_s = 1'b0; read_en_s = 1'b1;
        @(posedge clock); #1;
        tests++;
        if ({d1_s, d2_s, swr_s} !== {16'd48, 16'd49, 16'd1}) begin
            fails++;
            $display("FAIL small_init: got %0d %0d %0d, want 48 49 1", d1_s, d2_s, swr_s);
        end
        write_en_s = 1'b1; data_s = 16'hABCD; read1_s = 3'd7;
        @(posedge clock); #1;
        tests++;
        if (d1_s !== 16'hABCD || swr_s !== 16'hABCD) begin
            fails++;
            $display("FAIL small_bypass: d1=%h swr=%h, want abcd", d1_s, swr_s);
        end
        write_en_s = 1'b0; data_s = 16'h0; ctrl_jal_s = 1'b1; ctrl_d2_s = 1'b0;
        @(posedge clock); #1;
        tests++;
        if ({d1_s, d2_s, swr_s} !== {16'd0, 16'hABCD, 16'hABCD}) begin
            fails++;
            $display("FAIL small_roundtrip: got %h %h %h, want 0 abcd abcd", d1_s, d2_s, swr_s);
        end
        read_en_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init_table();
        test_bypass();
        test_select();
        test_zero_reg();
        test_random();
        test_sweep();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
